aes_key_expand: RTL

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : AES-128 key schedule generator. Emits round keys 0..10 on
//                consecutive cycles and keeps them in a readable 11-entry table.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic         done,
    output logic         table_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int          NUM_RK     = 11;
    localparam logic [3:0]  LAST_IDX   = 4'd10;

    // Byte b of the S-box lives at bits [8*(255-b) +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     rk_idx_q, rk_idx_d;
    logic           rk_valid_q, rk_valid_d;
    logic           done_q, done_d;
    logic           table_valid_q, table_valid_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic [127:0]   table_q [NUM_RK];
    logic [127:0]   table_d [NUM_RK];

    logic [31:0]    w0, w1, w2, w3, temp, n0, n1, n2, n3;
    logic [3:0]     next_idx;

    // Next round key derived from the key currently on the output register.
    always_comb begin
        next_idx = rk_idx_q + 4'd1;
        w0       = rk_q[127:96];
        w1       = rk_q[95:64];
        w2       = rk_q[63:32];
        w3       = rk_q[31:0];
        temp     = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                   ^ {rcon(next_idx), 24'h000000};
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
    end

    always_comb begin
        state_d       = state_q;
        rk_d          = '0;
        rk_idx_d      = '0;
        rk_valid_d    = 1'b0;
        done_d        = 1'b0;
        table_valid_d = table_valid_q;
        rd_key_d      = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            table_d[i] = table_q[i];
            if (rk_valid_q && (rk_idx_q == 4'(i))) begin
                table_d[i] = rk_q;
            end
            // Reads see the pre-write contents of the entry.
            if (rd_idx == 4'(i)) begin
                rd_key_d = table_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = EXPAND;
                    rk_d          = key;
                    rk_idx_d      = 4'd0;
                    rk_valid_d    = 1'b1;
                    table_valid_d = 1'b0;
                end
            end
            EXPAND: begin
                if (rk_idx_q == LAST_IDX) begin
                    state_d       = IDLE;
                    table_valid_d = 1'b1;
                end else begin
                    rk_d       = {n0, n1, n2, n3};
                    rk_idx_d   = next_idx;
                    rk_valid_d = 1'b1;
                    done_d     = (next_idx == LAST_IDX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rk_q          <= '0;
            rk_idx_q      <= '0;
            rk_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
            rd_key_q      <= '0;
            for (int i = 0; i < NUM_RK; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rk_q          <= rk_d;
            rk_idx_q      <= rk_idx_d;
            rk_valid_q    <= rk_valid_d;
            done_q        <= done_d;
            table_valid_q <= table_valid_d;
            rd_key_q      <= rd_key_d;
            for (int i = 0; i < NUM_RK; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign busy        = (state_q == EXPAND);
    assign rk_valid    = rk_valid_q;
    assign rk_idx      = rk_idx_q;
    assign rk          = rk_q;
    assign done        = done_q;
    assign table_valid = table_valid_q;
    assign rd_key      = rd_key_q;

endmodule
`default_nettype wire
